// File: rtl/eca_pkg.sv
// Shared opcodes and controller state encoding for the ECA run
// controller and the cell array it drives.
package eca_pkg;

    localparam logic [1:0] OP_INIT = 2'd0;
    localparam logic [1:0] OP_STEP = 2'd1;
    localparam logic [1:0] OP_HOLD = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPT,
        STEP,
        DRAIN
    } state_e;

    // The array only moves in LOAD and STEP; every other state freezes it.
    function automatic logic [1:0] state_op(state_e s);
        logic [1:0] o;
        o = OP_HOLD;
        unique case (1'b1)
            s == LOAD: o = OP_INIT;
            s == STEP: o = OP_STEP;
            default:   o = OP_HOLD;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/eca_run_ctrl_if.sv
// Row stream from the run controller: FIFO head plus valid/ready.
// The producer side is master, the row consumer is slave.
interface eca_run_ctrl_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] row_data;
    logic             row_last;
    logic             row_valid;
    logic             row_ready;

    modport master (
        output row_data,
        output row_last,
        output row_valid,
        input  row_ready
    );

    modport slave (
        input  row_data,
        input  row_last,
        input  row_valid,
        output row_ready
    );

endinterface

// File: rtl/eca_row_fifo.sv
// First-word-fall-through row buffer with full/empty/count.
// Head entry is visible on dout_o while the FIFO is not empty.
module eca_row_fifo #(
    parameter int DW    = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [DW-1:0]              din_i,
    input  logic                       pop_i,
    output logic [DW-1:0]              dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            assert (!(push_i && full_o));
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/eca_run_ctrl.sv
// Self-timed multi-generation run controller for the ECA cell ring,
// buffering one row per generation and streaming rows downstream.
module eca_run_ctrl
    import eca_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GEN_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [7:0]       rule_in,
    input  logic [GEN_W-1:0] num_gens,
    output logic             busy,
    output logic             done,
    output logic [1:0]       op,
    output logic [WIDTH-1:0] init_state,
    output logic [7:0]       rule,
    input  logic [WIDTH-1:0] ca_state,
    eca_run_ctrl_if.master   row
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] init_q, init_d;
    logic [7:0]       rule_q, rule_d;
    logic [GEN_W-1:0] ngen_q, ngen_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             push;
    logic             is_last;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_cnt;
    logic [WIDTH:0]   fifo_dout;

    // Compare happens before the increment, so gen_q never wraps.
    assign is_last = (gen_q == ngen_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            init_q  <= '0;
            rule_q  <= '0;
            ngen_q  <= '0;
            gen_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            assert (fifo_cnt <= CW'(DEPTH));
            state_q <= state_d;
            init_q  <= init_d;
            rule_q  <= rule_d;
            ngen_q  <= ngen_d;
            gen_q   <= gen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        rule_d  = rule_q;
        ngen_d  = ngen_q;
        gen_d   = gen_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    init_d  = seed;
                    rule_d  = rule_in;
                    ngen_d  = num_gens;
                    gen_d   = '0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = CAPT;
            CAPT: begin
                if (!fifo_full) begin
                    push    = 1'b1;
                    state_d = is_last ? DRAIN : STEP;
                end
            end
            STEP: begin
                gen_d   = gen_q + 1'b1;
                state_d = CAPT;
            end
            DRAIN: begin
                if (fifo_empty) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign op         = state_op(state_q);
    assign busy       = busy_q;
    assign done       = done_q;
    assign init_state = init_q;
    assign rule       = rule_q;

    eca_row_fifo #(
        .DW    (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   ({ca_state, is_last}),
        .pop_i   (row.row_ready),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign row.row_data  = fifo_dout[WIDTH:1];
    assign row.row_last  = fifo_dout[0] && !fifo_empty;
    assign row.row_valid = !fifo_empty;

endmodule

// File: tb/tb_eca_run_ctrl.sv
// Directed bench for eca_run_ctrl with a behavioural cell ring and
// a queue of expected rows checked at every row handshake.
module tb_eca_run_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] seed = '0;
    logic [7:0] rule_in = '0;
    logic [7:0] num_gens = '0;
    logic       busy;
    logic       done;
    logic [1:0] op;
    logic [7:0] init_state;
    logic [7:0] rule;
    logic [7:0] ca = '0;

    int n_cmp = 0;
    int n_err = 0;
    int n_rows = 0;
    int n_done = 0;
    int r_mark = 0;
    int d_mark = 0;

    logic [8:0] exp_q[$];

    eca_run_ctrl_if #(.WIDTH(8)) row_if ();

    eca_run_ctrl #(
        .WIDTH (8),
        .GEN_W (8),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seed       (seed),
        .rule_in    (rule_in),
        .num_gens   (num_gens),
        .busy       (busy),
        .done       (done),
        .op         (op),
        .init_state (init_state),
        .rule       (rule),
        .ca_state   (ca),
        .row        (row_if)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] eca_next(input logic [7:0] s,
                                            input logic [7:0] r);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n[i] = r[{s[(i + 1) % 8], s[i], s[(i + 7) % 8]}];
        end
        return n;
    endfunction

    // Cell ring model: loads on INIT, steps on STEP, otherwise holds.
    always @(posedge clk) begin
        case (op)
            2'd0:    ca <= init_state;
            2'd1:    ca <= eca_next(ca, rule);
            default: ca <= ca;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) n_done++;
            if (row_if.row_valid && row_if.row_ready) begin
                logic [8:0] e;
                n_rows++;
                n_cmp++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL sb_unexpected: observed row %0h expected none",
                           row_if.row_data);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    assert (row_if.row_data === e[8:1]) else begin
                        n_err++;
                        $error("FAIL row_data: observed %0h expected %0h",
                               row_if.row_data, e[8:1]);
                    end
                    n_cmp++;
                    assert (row_if.row_last === e[0]) else begin
                        n_err++;
                        $error("FAIL row_last: observed %0b expected %0b",
                               row_if.row_last, e[0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        r_mark = n_rows;
        d_mark = n_done;
    endtask

    task automatic run_start(input logic [7:0] s, input logic [7:0] r,
                             input logic [7:0] ng);
        logic [7:0] x;
        x = s;
        for (int g = 0; g <= int'(ng); g++) begin
            exp_q.push_back({x, g == int'(ng)});
            x = eca_next(x, r);
        end
        @(posedge clk); #1;
        seed     = s;
        rule_in  = r;
        num_gens = ng;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget,
                             input bit toggle, input int exp_rows);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (toggle) row_if.row_ready = ~row_if.row_ready;
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_cmp++;
        assert (seen) else begin
            n_err++;
            $error("FAIL %s_timeout: observed no done expected done", tag);
        end
        chk({tag, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        @(negedge clk);
        chk({tag, "_rows"}, n_rows - r_mark, exp_rows);
        chk({tag, "_done_cnt"}, n_done - d_mark, 1);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
        row_if.row_ready = 1'b1;
    endtask

    initial begin
        logic [7:0] g4;
        int steps;

        row_if.row_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_op", op, 2);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", row_if.row_valid, 0);
        chk("rst_last", row_if.row_last, 0);
        chk("rst_data", row_if.row_data, 0);
        chk("rst_init", init_state, 0);
        chk("rst_rule", rule, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // basic rule-150 run, consumer always ready
        mark();
        run_start(8'h10, 8'd150, 8'd3);
        wait_done("t1", 100, 1'b0, 4);

        // stall with consumer blocked
        row_if.row_ready = 1'b0;
        mark();
        run_start(8'h10, 8'd150, 8'd9);
        repeat (25) @(negedge clk);
        g4 = 8'h10;
        repeat (4) g4 = eca_next(g4, 8'd150);
        chk("t2_valid", row_if.row_valid, 1);
        chk("t2_head", row_if.row_data, 8'h10);
        chk("t2_op_hold", op, 2);
        chk("t2_busy", busy, 1);
        chk("t2_ca", ca, g4);
        repeat (5) @(negedge clk);
        chk("t2_ca_stable", ca, g4);
        chk("t2_rows_held", n_rows - r_mark, 0);
        row_if.row_ready = 1'b1;
        wait_done("t2", 200, 1'b0, 10);

        // single-row run
        mark();
        run_start(8'hA5, 8'd150, 8'd0);
        wait_done("t3", 100, 1'b0, 1);

        // restart and rule change mid-run are ignored
        mark();
        run_start(8'h10, 8'd150, 8'd3);
        start    = 1'b1;
        rule_in  = 8'd90;
        seed     = 8'hFF;
        num_gens = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("t4_busy", busy, 1);
        chk("t4_rule", rule, 150);
        chk("t4_init", init_state, 8'h10);
        wait_done("t4", 100, 1'b0, 4);
        repeat (4) @(negedge clk);
        chk("t4_idle_busy", busy, 0);

        // reset in the second STEP with two rows buffered
        row_if.row_ready = 1'b0;
        run_start(8'h10, 8'd150, 8'd9);
        steps = 0;
        for (int i = 0; i < 40 && steps < 2; i++) begin
            @(negedge clk);
            if (op == 2'd1) steps++;
        end
        chk("t5_reach_step", steps, 2);
        chk("t5_pre_valid", row_if.row_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_valid", row_if.row_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_op", op, 2);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        row_if.row_ready = 1'b1;
        mark();
        run_start(8'h01, 8'd90, 8'd6);
        wait_done("t5", 100, 1'b0, 7);

        // consumer toggles ready every cycle
        mark();
        row_if.row_ready = 1'b0;
        run_start(8'h01, 8'd30, 8'd11);
        wait_done("t6", 300, 1'b1, 12);

        // longest run: counter must not wrap before the compare
        mark();
        run_start(8'h10, 8'd110, 8'd255);
        wait_done("t7", 2000, 1'b0, 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
